// File: rtl/wb_btn_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_btn_led_pkg
//  Purpose  : Register offsets, reset constants and bus helpers shared by the
//             Wishbone button/LED controller.
//  Revision : 1.0  initial release
// ============================================================================
package wb_btn_led_pkg;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] REG_BTN_STATE = 5'h00;
    localparam logic [4:0] REG_BTN_EVENT = 5'h04;
    localparam logic [4:0] REG_IRQ_EN    = 5'h08;
    localparam logic [4:0] REG_LED_OUT   = 5'h0C;
    localparam logic [4:0] REG_LED_BLINK = 5'h10;
    localparam logic [4:0] REG_BLINK_DIV = 5'h14;

    // Reset constants
    localparam logic [31:0] C_BASE_ADDR_DEF     = 32'h3000_0000;
    localparam logic [15:0] C_BLINK_DIV_RST_DEF = 16'd1000;

    // Expand the four byte selects into a 32-bit write mask
    function automatic logic [31:0] f_byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_btn_led_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : One button lane: 2-FF synchroniser, optional inversion, debounce
//             counter and a one-cycle pulse flagging an accepted press.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_rise
);

    localparam int            CW         = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_sample;
    logic          w_accept;

    // Inversion happens after the synchroniser so the flops see the raw pad
    assign w_sample = r_sync2 ^ ACTIVE_LOW;
    // A change is accepted when the sample has differed for DEB_CYCLES samples
    assign w_accept = (w_sample != r_stable) && (r_cnt == C_CNT_LAST);

    // Two-stage synchroniser for the asynchronous pad
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter: restart whenever the sample agrees with the stable level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_sample == r_stable) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= w_sample;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_stable;
    // High in the cycle whose closing edge raises the stable level
    assign o_rise  = w_accept & w_sample;

endmodule
`default_nettype wire

// File: rtl/wb_btn_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wb_btn_led_ctrl
//  Purpose  : Wishbone slave driving debounced push-buttons with sticky press
//             capture and interrupt, plus LEDs with per-LED blink mode.
//  Revision : 1.0  initial release
// ============================================================================
module wb_btn_led_ctrl
    import wb_btn_led_pkg::*;
#(
    parameter int          NUM_BTN        = 3,
    parameter int          NUM_LED        = 4,
    parameter int          DEB_CYCLES     = 16,
    parameter bit          BTN_ACTIVE_LOW = 1'b0,
    parameter logic [31:0] BASE_ADDR      = C_BASE_ADDR_DEF,
    parameter logic [15:0] BLINK_DIV_RST  = C_BLINK_DIV_RST_DEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [NUM_BTN-1:0]         btn_i,
    output logic [NUM_LED-1:0]         led_o,
    output logic [NUM_BTN+NUM_LED-1:0] io_oeb_o,
    output logic                       irq_o
);

    logic               w_req;
    logic               w_start;
    logic               w_wr;
    logic [4:0]         w_off;
    logic [31:0]        w_mask;
    logic [31:0]        w_rdata;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_evt_clr;
    logic               w_unused;

    logic               r_ack;
    logic [31:0]        r_dat;
    logic [NUM_BTN-1:0] r_btn_event;
    logic [NUM_BTN-1:0] r_irq_en;
    logic [NUM_LED-1:0] r_led_out;
    logic [NUM_LED-1:0] r_led_blink;
    logic [NUM_LED-1:0] r_led;
    logic [15:0]        r_blink_div;
    logic [15:0]        r_pcnt;
    logic               r_phase;

    // One debouncer per button lane
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_deb (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .i_pad   (btn_i[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    // Bus decode: a transfer starts on a request that was not acked last cycle,
    // so a held request gets one ack every other cycle.
    assign w_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_start = w_req & ~r_ack;
    assign w_wr    = w_start & wbs_we_i;
    assign w_off   = {wbs_adr_i[4:2], 2'b00};
    assign w_mask  = f_byte_mask(wbs_sel_i);

    // Byte-lane and data bits beyond the register widths are don't-care
    assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i, w_mask};

    // W1C clear vector for the sticky event flags
    assign w_evt_clr = (w_wr && (w_off == REG_BTN_EVENT)) ?
                       (wbs_dat_i[NUM_BTN-1:0] & w_mask[NUM_BTN-1:0]) : '0;

    // Read multiplexer, zero-extended; unmapped offsets read zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_BTN_STATE: w_rdata = 32'(w_level);
            REG_BTN_EVENT: w_rdata = 32'(r_btn_event);
            REG_IRQ_EN:    w_rdata = 32'(r_irq_en);
            REG_LED_OUT:   w_rdata = 32'(r_led_out);
            REG_LED_BLINK: w_rdata = 32'(r_led_blink);
            REG_BLINK_DIV: w_rdata = 32'(r_blink_div);
            default:       w_rdata = '0;
        endcase
    end

    // Registered ack and read data; data is zero outside read acks
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_start;
            r_dat <= (w_start && !wbs_we_i) ? w_rdata : '0;
        end
    end

    // Control registers with byte-lane writes; a press beats a same-cycle W1C
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_btn_event <= '0;
            r_irq_en    <= '0;
            r_led_out   <= '0;
            r_led_blink <= '0;
            r_blink_div <= BLINK_DIV_RST;
        end else begin
            r_btn_event <= (r_btn_event & ~w_evt_clr) | w_rise;
            if (w_wr) begin
                case (w_off)
                    REG_IRQ_EN:
                        r_irq_en <= (r_irq_en & ~w_mask[NUM_BTN-1:0]) |
                                    (wbs_dat_i[NUM_BTN-1:0] & w_mask[NUM_BTN-1:0]);
                    REG_LED_OUT:
                        r_led_out <= (r_led_out & ~w_mask[NUM_LED-1:0]) |
                                     (wbs_dat_i[NUM_LED-1:0] & w_mask[NUM_LED-1:0]);
                    REG_LED_BLINK:
                        r_led_blink <= (r_led_blink & ~w_mask[NUM_LED-1:0]) |
                                       (wbs_dat_i[NUM_LED-1:0] & w_mask[NUM_LED-1:0]);
                    REG_BLINK_DIV:
                        r_blink_div <= (r_blink_div & ~w_mask[15:0]) |
                                       (wbs_dat_i[15:0] & w_mask[15:0]);
                    default: ;
                endcase
            end
        end
    end

    // Blink prescaler; >= lets a smaller divider take effect immediately
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_pcnt >= r_blink_div) begin
            r_pcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    // Registered LED drive: blinking LEDs are gated by the phase bit
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_led <= '0;
        end else begin
            r_led <= r_led_out & (~r_led_blink | {NUM_LED{r_phase}});
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign led_o     = r_led;
    assign irq_o     = |(r_btn_event & r_irq_en);
    // Buttons are inputs (oeb=1), LEDs are outputs (oeb=0) in the upper bits
    assign io_oeb_o  = {{NUM_LED{1'b0}}, {NUM_BTN{1'b1}}};

endmodule
`default_nettype wire
